// File: rtl/load_byte_fetch.sv
// Single-byte load engine: fetches the aligned word and returns the addressed byte lane.
// Optional request timeout compiled in with `define LBF_TIMEOUT_EN.
module load_byte_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  byte_out,
    output logic        valid,
    output logic        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [1:0]  lane_q, lane_d;
    logic        mem_req_q, mem_req_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic [7:0]  lane_byte;

`ifdef LBF_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        lane_byte = mem_rdata[7:0];
        case (lane_q)
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        lane_d     = lane_q;
        byte_d     = byte_q;
        valid_d    = 1'b0;
`ifdef LBF_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = REQ;
                    mem_addr_d = {addr[31:2], 2'b00};
                    lane_d     = addr[1:0];
`ifdef LBF_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = DONE;
                    byte_d  = lane_byte;
                    valid_d = 1'b1;
                end
`ifdef LBF_TIMEOUT_EN
                // An ack in the final allowed cycle takes priority over the abort.
                else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    byte_d  = 8'h00;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= 32'h0;
            lane_q     <= 2'd0;
            mem_req_q  <= 1'b0;
            byte_q     <= 8'h00;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            lane_q     <= lane_d;
            mem_req_q  <= mem_req_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
        end
    end

`ifdef LBF_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy     = (state_q != IDLE);
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign byte_out = byte_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_load_byte_fetch.sv
// Self-checking bench for load_byte_fetch: directed scenarios plus randomized loads
// checked against a byte-lane reference model.
module tb_load_byte_fetch;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] addr;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [7:0]  byte_out;
    logic        valid;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LBF_TIMEOUT_EN
    localparam int MAX_WAIT = 4;
`else
    localparam int MAX_WAIT = 7;
`endif

    load_byte_fetch #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .addr      (addr),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .byte_out  (byte_out),
        .valid     (valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: little-endian byte lane of the returned word.
    function automatic logic [7:0] model_byte(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> (8 * int'(a[1:0]));
        return sh[7:0];
    endfunction

    // Issue one load; ack arrives in REQ cycle w (1-based).
    task automatic do_load(input logic [31:0] a, input logic [31:0] d, input int w,
                           input string tag);
        logic [7:0]  exp_b;
        logic [31:0] exp_a;
        exp_b = model_byte(a, d);
        exp_a = a & 32'hFFFF_FFFC;
        @(negedge clk);
        start = 1'b1; addr = a; mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0; addr = $urandom;
        for (int i = 1; i <= w; i++) begin
            n_checks++;
            if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== exp_a || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s req_cycle%0d: mem_req=%b busy=%b mem_addr=%h valid=%b, need 1 1 %h 0",
                         tag, i, mem_req, busy, mem_addr, valid, exp_a);
            end
            mem_ack   = (i == w);
            mem_rdata = (i == w) ? d : $urandom;
            @(negedge clk);
        end
        mem_ack = 1'b0; mem_rdata = $urandom;
        n_checks++;
        if (valid !== 1'b1 || err !== 1'b0 || byte_out !== exp_b || mem_req !== 1'b0 ||
            busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done: valid=%b err=%b byte_out=%h mem_req=%b busy=%b, need 1 0 %h 0 1",
                     tag, valid, err, byte_out, mem_req, busy, exp_b);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || byte_out !== exp_b) begin
            n_fail++;
            $display("FAIL %s idle: valid=%b busy=%b byte_out=%h, need 0 0 %h",
                     tag, valid, busy, byte_out, exp_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; addr = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 || byte_out !== 8'h00 ||
            valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: busy=%b mem_req=%b mem_addr=%h byte_out=%h valid=%b err=%b, need all 0",
                     busy, mem_req, mem_addr, byte_out, valid, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lane_select();
        do_load(32'h0000_1003, 32'hA1B2_C3D4, 1, "lane_select");
        n_checks++;
        if (byte_out !== 8'hA1) begin
            n_fail++;
            $display("FAIL lane_select_const: byte_out=%h need a1", byte_out);
        end
        do_load(32'h0000_1000, 32'hA1B2_C3D4, 1, "lane0");
        do_load(32'h0000_1001, 32'hA1B2_C3D4, 1, "lane1");
        do_load(32'h0000_1002, 32'hA1B2_C3D4, 1, "lane2");
        n_checks++;
        if (byte_out !== 8'hB2) begin
            n_fail++;
            $display("FAIL lane2_const: byte_out=%h need b2", byte_out);
        end
    endtask

    task automatic test_wait_states();
        do_load(32'h0000_2001, 32'h1234_5678, MAX_WAIT < 5 ? MAX_WAIT : 5, "wait_states");
        n_checks++;
        if (byte_out !== 8'h56) begin
            n_fail++;
            $display("FAIL wait_states_const: byte_out=%h need 56", byte_out);
        end
    endtask

    task automatic test_ignored();
        @(negedge clk);
        start = 1'b1; addr = 32'h0000_3002;
        @(negedge clk);
        start = 1'b1; addr = 32'hFFFF_FFFF; // extra start in REQ
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL ignored_req: mem_req=%b mem_addr=%h, need 1 00003000", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        @(negedge clk);
        mem_ack = 1'b0; start = 1'b1; // extra start in DONE
        n_checks++;
        if (valid !== 1'b1 || byte_out !== 8'h22) begin
            n_fail++;
            $display("FAIL ignored_done: valid=%b byte_out=%h, need 1 22", valid, byte_out);
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
            n_checks++;
            if (busy !== 1'b0 || mem_req !== 1'b0 || valid !== 1'b0 || byte_out !== 8'h22) begin
                n_fail++;
                $display("FAIL ignored_idle%0d: busy=%b mem_req=%b valid=%b byte_out=%h, need 0 0 0 22",
                         i, busy, mem_req, valid, byte_out);
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        int          w;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            d = $urandom;
            w = $urandom_range(MAX_WAIT, 1);
            do_load(a, d, w, "random");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; addr = 32'h0000_4001;
        @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0 || byte_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_async: mem_req=%b busy=%b mem_addr=%h byte_out=%h, need 0 0 0 0",
                     mem_req, busy, mem_addr, byte_out);
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_release%0d: valid=%b err=%b busy=%b, need 0 0 0",
                         i, valid, err, busy);
            end
        end
        mem_ack = 1'b0;
        do_load(32'h0000_0000, 32'h0000_00FF, 1, "after_reset");
        n_checks++;
        if (byte_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL after_reset_const: byte_out=%h need ff", byte_out);
        end
    endtask

`ifdef LBF_TIMEOUT_EN
    task automatic test_timeout();
        do_load(32'h0000_5000, 32'h0000_005A, 2, "pre_timeout");
        @(negedge clk);
        start = 1'b1; addr = 32'h0000_5003;
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (mem_req !== 1'b1 || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_req%0d: mem_req=%b valid=%b, need 1 0", i, mem_req, valid);
            end
            mem_rdata = $urandom;
            @(negedge clk);
        end
        n_checks++;
        if (mem_req !== 1'b0 || valid !== 1'b1 || err !== 1'b1 || byte_out !== 8'h00) begin
            n_fail++;
            $display("FAIL timeout_done: mem_req=%b valid=%b err=%b byte_out=%h, need 0 1 1 00",
                     mem_req, valid, err, byte_out);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: valid=%b err=%b busy=%b, need 0 0 0", valid, err, busy);
        end
        do_load(32'h0000_5003, 32'hC7AA_BBCC, 4, "ack_at_limit");
    endtask
`endif

    initial begin
        test_reset();
        test_lane_select();
        test_wait_states();
        test_ignored();
        test_random();
        test_reset_mid();
`ifdef LBF_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
